sr_latch_driver: RTL

Synchronous command front-end for the NAND-based SR latch. Accepts set/reset requests on a valid/ready handshake and drives the latch's four active-low inputs (s0, s1, r1, r0) with a clean, width-controlled pulse, never asserting set and reset together. It then waits a settle interval and checks the latch's q/q_bar feedback through a synchronizer. It sits between clocked control logic and the asynchronous latch, forming the driving end of the latch's set/reset interface.

---
 rtl/sr_latch_driver.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sr_latch_driver.sv
// Clocked set/reset front-end for a NAND SR latch: handshake in, width-controlled
// active-low pulse out, settle wait, then feedback check. Optional: SR_DRV_VERIFY_EN.
module sr_latch_driver #(
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_set,
  output logic req_ready,
  output logic s0,
  output logic s1,
  output logic r1,
  output logic r0,
  input  logic q,
  input  logic q_bar,
  output logic q_sync,
  output logic done,
  output logic err
);

  typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CHECK} state_e;

  localparam logic [7:0] PULSE_LOAD  = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       cmd_q, cmd_d;
  logic       accept;
  logic       mismatch;

  logic       s_n_q, s_n_d;
  logic       r_n_q, r_n_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  assign accept = (state_q == IDLE) && req_valid;

`ifdef SR_DRV_VERIFY_EN
  logic [1:0] q_sync_q;
  logic [1:0] q_bar_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_sync_q     <= 2'b00;
      q_bar_sync_q <= 2'b11;
    end else begin
      q_sync_q     <= {q_sync_q[0], q};
      q_bar_sync_q <= {q_bar_sync_q[0], q_bar};
    end
  end

  assign q_sync = q_sync_q[1];
  // Both-equal (illegal) feedback always fails one of the two terms.
  assign mismatch = (q_sync_q[1] != cmd_q) || (q_bar_sync_q[1] != ~cmd_q);
`else
  logic unused_feedback;
  assign unused_feedback = q ^ q_bar;
  assign q_sync          = 1'b0;
  assign mismatch        = 1'b0;
`endif

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      cmd_q   <= 1'b0;
      s_n_q   <= 1'b1;
      r_n_q   <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      s_n_q   <= s_n_d;
      r_n_q   <= r_n_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = PULSE;
          cnt_d   = PULSE_LOAD;
          cmd_d   = req_set;
        end
      end
      PULSE: begin
        if (cnt_q == 8'd0) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == 8'd0) state_d = CHECK;
        else               cnt_d   = cnt_q - 8'd1;
      end
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode of the next state, registered so latch drives are glitch-free
  // and line up with the state they belong to.
  always_comb begin
    ready_d = (state_d == IDLE);
    s_n_d   = !((state_d == PULSE) &&  cmd_d);
    r_n_d   = !((state_d == PULSE) && !cmd_d);
    done_d  = (state_d == CHECK);
    err_d   = err_q;
    if (accept)                  err_d = 1'b0;
    else if (state_d == CHECK)   err_d = mismatch;
  end

  assign req_ready = ready_q;
  assign s0        = s_n_q;
  assign s1        = s_n_q;
  assign r0        = r_n_q;
  assign r1        = r_n_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
